conv_ctrl_multi: RTL and testbench

Parametrised control and performance-monitor unit for up to NUM_UNITS convolution engines. It exposes one APB slave register file and merges two jobs into one block: per-unit start/done handshaking and per-unit cycle counting. Additions are a saturating counter, an overflow flag, write-1-to-clear status and a maskable interrupt. It sits between the APB interconnect and the conv_module instances inside the accelerator top.

---
 rtl/conv_ctrl_multi.sv | 189 ++++++++++++++++++
 tb/tb_conv_ctrl_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_multi.sv
// conv_ctrl_multi
//   APB register file that starts up to NUM_UNITS convolution engines and
//   measures how many cycles each run takes. Each unit has its own
//   start/done handshake, a saturating cycle counter, sticky DONE and OVF
//   bits (write-1-to-clear) and a maskable interrupt.
//
// Ports
//   CLK, RESET        clock and asynchronous active-high reset
//   PADDR..PWDATA     APB slave inputs (only PADDR[15:0] decoded)
//   PRDATA            registered read data, captured in the setup phase
//   PREADY            constant 1 (zero-wait transfers)
//   PSLVERR           access phase to an unmapped address
//   unit_start        one-cycle start pulse per engine
//   unit_done         per-engine completion, level or pulse
//   IRQ               OR of DONE & IRQ_MASK
//
// Register map
//   0x00 CTRL (WO, reads 0)   0x04 BUSY (RO)   0x08 DONE (W1C)
//   0x0C IRQ_MASK (RW)        0x10 OVF (W1C)   0x40+4*i COUNT[i] (RO)
//
// Per-unit state machine
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | engine not running; a CTRL start request launches a run
//   ST_RUN  | engine running; counter advances each cycle until done

module conv_ctrl_multi #(
    parameter int NUM_UNITS     = 4,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PADDR,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 IRQ
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } unit_state_t;

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

    unit_state_t              state_q [NUM_UNITS];
    unit_state_t              state_d [NUM_UNITS];
    logic [COUNTER_WIDTH-1:0] count_q [NUM_UNITS];
    logic [COUNTER_WIDTH-1:0] count_d [NUM_UNITS];
    logic [NUM_UNITS-1:0]     start_q, start_d;
    logic [NUM_UNITS-1:0]     done_q, done_d;
    logic [NUM_UNITS-1:0]     ovf_q, ovf_d;
    logic [NUM_UNITS-1:0]     mask_q, mask_d;
    logic [31:0]              prdata_q, prdata_d;
    logic [NUM_UNITS-1:0]     busy;

    logic [15:0] addr;
    logic [3:0]  count_idx;
    logic        sel_ctrl, sel_busy, sel_done, sel_mask, sel_ovf, sel_count;
    logic        addr_mapped;
    logic        wr_en, rd_setup;
    logic [NUM_UNITS-1:0] start_req, done_w1c, ovf_w1c;
    logic [31:0] rdata;

    // Upper address bits are ignored by design; upper data bits are unused.
    logic unused_bits;
    assign unused_bits = ^{PADDR[31:16], PWDATA};

    // Address decode
    always_comb begin
        addr        = PADDR[15:0];
        count_idx   = addr[5:2];
        sel_ctrl    = (addr == 16'h0000);
        sel_busy    = (addr == 16'h0004);
        sel_done    = (addr == 16'h0008);
        sel_mask    = (addr == 16'h000C);
        sel_ovf     = (addr == 16'h0010);
        sel_count   = (addr[15:6] == 10'd1) && (addr[1:0] == 2'b00) &&
                      ({28'd0, count_idx} < 32'(NUM_UNITS));
        addr_mapped = sel_ctrl | sel_busy | sel_done | sel_mask | sel_ovf | sel_count;
    end

    always_comb begin
        wr_en     = PSEL & PENABLE & PWRITE;
        rd_setup  = PSEL & ~PENABLE & ~PWRITE;
        start_req = (wr_en && sel_ctrl) ? PWDATA[NUM_UNITS-1:0] : '0;
        done_w1c  = (wr_en && sel_done) ? PWDATA[NUM_UNITS-1:0] : '0;
        ovf_w1c   = (wr_en && sel_ovf)  ? PWDATA[NUM_UNITS-1:0] : '0;
        mask_d    = (wr_en && sel_mask) ? PWDATA[NUM_UNITS-1:0] : mask_q;
    end

    // Per-unit next state. Hardware sets are applied after the W1C clear so
    // a set on the same edge wins. A start only matters in ST_IDLE, so a
    // start that coincides with done on a busy unit is dropped.
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            start_d[i] = 1'b0;
            done_d[i]  = done_q[i] & ~done_w1c[i];
            ovf_d[i]   = ovf_q[i] & ~ovf_w1c[i];
            busy[i]    = (state_q[i] == ST_RUN);

            case (state_q[i])
                ST_IDLE: begin
                    if (start_req[i]) begin
                        state_d[i] = ST_RUN;
                        start_d[i] = 1'b1;
                        count_d[i] = '0;
                        done_d[i]  = 1'b0;
                        ovf_d[i]   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (count_q[i] == COUNT_MAX) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + COUNT_ONE;
                    end
                    if (unit_done[i]) begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Read mux; everything not explicitly driven reads 0.
    always_comb begin
        rdata = '0;
        if (sel_busy) begin
            rdata[NUM_UNITS-1:0] = busy;
        end else if (sel_done) begin
            rdata[NUM_UNITS-1:0] = done_q;
        end else if (sel_mask) begin
            rdata[NUM_UNITS-1:0] = mask_q;
        end else if (sel_ovf) begin
            rdata[NUM_UNITS-1:0] = ovf_q;
        end else if (sel_count) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (count_idx == 4'(i)) begin
                    rdata[COUNTER_WIDTH-1:0] = count_q[i];
                end
            end
        end
        prdata_d = rd_setup ? rdata : prdata_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= '0;
            end
            start_q  <= '0;
            done_q   <= '0;
            ovf_q    <= '0;
            mask_q   <= '0;
            prdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            start_q  <= start_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            mask_q   <= mask_d;
            prdata_q <= prdata_d;
        end
    end

    assign PRDATA     = prdata_q;
    assign PREADY     = 1'b1;
    assign PSLVERR    = PSEL & PENABLE & ~addr_mapped;
    assign unit_start = start_q;
    assign IRQ        = |(done_q & mask_q);

endmodule

// File: tb/tb_conv_ctrl_multi.sv
module tb_conv_ctrl_multi;

    localparam int NU = 4;
    localparam int CW = 4;

    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_BUSY  = 32'h04;
    localparam logic [31:0] A_DONE  = 32'h08;
    localparam logic [31:0] A_MASK  = 32'h0C;
    localparam logic [31:0] A_OVF   = 32'h10;
    localparam logic [31:0] A_CNT0  = 32'h40;
    localparam logic [31:0] A_CNT1  = 32'h44;
    localparam logic [31:0] A_CNT3  = 32'h4C;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [31:0]   PADDR = '0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE = 1'b0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [NU-1:0] unit_start;
    logic [NU-1:0] unit_done = '0;
    logic          IRQ;

    int checks = 0;
    int failures = 0;

    conv_ctrl_multi #(.NUM_UNITS(NU), .COUNTER_WIDTH(CW)) dut (
        .CLK(CLK), .RESET(RESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .unit_start(unit_start), .unit_done(unit_done), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1 d = PRDATA; err = PSLVERR;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_read(a, d, e);
        chk(name, d, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] d;
        logic e;

        vecs[0]  = '{1'b1, A_MASK,        32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, A_MASK,        32'h0,         32'hF, 1'b0};
        vecs[2]  = '{1'b1, A_MASK,        32'h0000_0005, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, A_MASK,        32'h0,         32'h5, 1'b0};
        vecs[4]  = '{1'b0, A_CTRL,        32'h0,         32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h14,        32'h0,         32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h50,        32'h0,         32'h0, 1'b1};
        vecs[7]  = '{1'b1, 32'h50,        32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h14,        32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, A_MASK,        32'h0,         32'h5, 1'b0};
        vecs[10] = '{1'b0, 32'h0001_000C, 32'h0,         32'h5, 1'b0};
        vecs[11] = '{1'b0, A_CNT3,        32'h0,         32'h0, 1'b0};
        vecs[12] = '{1'b1, A_MASK,        32'h0,         32'h0, 1'b0};
        vecs[13] = '{1'b0, A_MASK,        32'h0,         32'h0, 1'b0};

        // Reset state
        #1;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_start", {28'd0, unit_start}, 32'h0);
        chk("rst_irq", {31'd0, IRQ}, 32'h0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
        chk("rst_pready", {31'd0, PREADY}, 32'h1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        rd_chk("rst_busy", A_BUSY, 32'h0);
        rd_chk("rst_done", A_DONE, 32'h0);
        rd_chk("rst_cnt0", A_CNT0, 32'h0);

        // Register-level vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
            end else begin
                apb_read(vecs[i].addr, d, e);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            end
            chk($sformatf("vec%0d_pslverr", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        end

        // Basic run: done sampled 10 cycles after the pulse -> count 11
        wr(A_CTRL, 32'h1);
        chk("basic_pulse", {28'd0, unit_start}, 32'h1);
        @(negedge CLK);
        chk("basic_pulse_end", {28'd0, unit_start}, 32'h0);
        repeat (9) @(negedge CLK);
        unit_done = 4'b0001;
        @(negedge CLK);
        unit_done = '0;
        rd_chk("basic_busy", A_BUSY, 32'h0);
        rd_chk("basic_done", A_DONE, 32'h1);
        rd_chk("basic_cnt0", A_CNT0, 32'd11);
        chk("basic_irq_masked", {31'd0, IRQ}, 32'h0);

        // Restart while busy: no second pulse, counter undisturbed
        wr(A_CTRL, 32'h2);
        chk("restart_pulse", {28'd0, unit_start}, 32'h2);
        repeat (3) @(negedge CLK);
        wr(A_CTRL, 32'h2);
        chk("restart_no_pulse", {28'd0, unit_start}, 32'h0);
        @(negedge CLK);
        chk("restart_no_pulse2", {28'd0, unit_start}, 32'h0);
        unit_done = 4'b0010;
        @(negedge CLK);
        unit_done = '0;
        rd_chk("restart_cnt1", A_CNT1, 32'd8);

        // Start and done on the same edge for a busy unit: done wins
        wr(A_CTRL, 32'h2);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_CTRL; PWDATA = 32'h2;
        @(negedge CLK);
        PENABLE = 1'b1;
        unit_done = 4'b0010;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        unit_done = '0;
        chk("race_start_ignored", {28'd0, unit_start}, 32'h0);
        rd_chk("race_busy", A_BUSY, 32'h0);
        rd_chk("race_done", A_DONE, 32'h3);
        rd_chk("race_cnt1", A_CNT1, 32'd3);

        // Multi-start and saturation of the 4-bit counters
        wr(A_CTRL, 32'hF);
        chk("multi_pulse", {28'd0, unit_start}, 32'hF);
        rd_chk("multi_busy", A_BUSY, 32'hF);
        rd_chk("multi_done_cleared", A_DONE, 32'h0);
        repeat (20) @(negedge CLK);
        rd_chk("sat_cnt3", A_CNT3, 32'hF);
        rd_chk("sat_ovf", A_OVF, 32'hF);
        rd_chk("sat_busy", A_BUSY, 32'hF);
        unit_done = 4'hF;
        @(negedge CLK);
        unit_done = '0;
        rd_chk("sat_busy_after", A_BUSY, 32'h0);
        rd_chk("sat_done_after", A_DONE, 32'hF);
        wr(A_OVF, 32'h5);
        rd_chk("ovf_w1c_part", A_OVF, 32'hA);
        wr(A_OVF, 32'hA);
        rd_chk("ovf_w1c_all", A_OVF, 32'h0);
        rd_chk("sat_cnt0_frozen", A_CNT0, 32'hF);

        // Interrupt and W1C/set race
        wr(A_MASK, 32'h4);
        chk("irq_masked_done", {31'd0, IRQ}, 32'h1);
        wr(A_DONE, 32'h4);
        chk("irq_after_w1c", {31'd0, IRQ}, 32'h0);
        rd_chk("done_after_w1c", A_DONE, 32'hB);
        wr(A_CTRL, 32'h4);
        repeat (3) @(negedge CLK);
        unit_done = 4'b0100;
        chk("irq_before_done", {31'd0, IRQ}, 32'h0);
        @(negedge CLK);
        unit_done = '0;
        chk("irq_rise", {31'd0, IRQ}, 32'h1);
        wr(A_CTRL, 32'h4);
        chk("irq_cleared_by_start", {31'd0, IRQ}, 32'h0);
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DONE; PWDATA = 32'h4;
        @(negedge CLK);
        PENABLE = 1'b1;
        unit_done = 4'b0100;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        unit_done = '0;
        chk("w1c_race_irq", {31'd0, IRQ}, 32'h1);
        rd_chk("w1c_race_done", A_DONE, 32'hF);

        // Asynchronous reset in the middle of a run
        wr(A_CTRL, 32'h8);
        chk("pre_rst_pulse", {28'd0, unit_start}, 32'h8);
        #2 RESET = 1'b1;
        #1;
        chk("arst_start", {28'd0, unit_start}, 32'h0);
        chk("arst_irq", {31'd0, IRQ}, 32'h0);
        chk("arst_prdata", PRDATA, 32'h0);
        chk("arst_pslverr", {31'd0, PSLVERR}, 32'h0);
        chk("arst_pready", {31'd0, PREADY}, 32'h1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_no_pulse", {28'd0, unit_start}, 32'h0);
        rd_chk("post_rst_busy", A_BUSY, 32'h0);
        rd_chk("post_rst_done", A_DONE, 32'h0);
        rd_chk("post_rst_cnt0", A_CNT0, 32'h0);
        rd_chk("post_rst_mask", A_MASK, 32'h0);
        rd_chk("post_rst_ovf", A_OVF, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
